// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter with pending-write scoreboard (optional WB_BYPASS_EN forwarding)
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 L_S,
    output logic [AW-1:0]        Wt_addr,
    output logic [DW-1:0]        wt_data,
    input  logic                 iss_vld,
    input  logic [AW-1:0]        iss_addr,
    input  logic [AW-1:0]        chk_addr_A,
    input  logic [AW-1:0]        chk_addr_B,
    output logic                 busy_A,
    output logic                 busy_B,
`ifdef WB_BYPASS_EN
    output logic                 byp_vld_A,
    output logic                 byp_vld_B,
    output logic [DW-1:0]        byp_data_A,
    output logic [DW-1:0]        byp_data_B,
`endif
    output logic [2**AW-1:0]     pend
);
    logic [1:0]        ptr;
    logic [1:0]        ptr_n;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   pick;
    logic [AW-1:0]     win_addr;
    logic [DW-1:0]     win_data;
    logic [2**AW-1:0]  set_v;
    logic [2**AW-1:0]  clr_v;
    always_comb begin
        rot = ptr == 2'd1 ? {req[0], req[2], req[1]} :
              ptr == 2'd2 ? {req[1], req[0], req[2]} : req;
        pick = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
        gnt = !rst ? 3'b000 :
              ptr == 2'd1 ? {pick[1], pick[0], pick[2]} :
              ptr == 2'd2 ? {pick[0], pick[2], pick[1]} : pick;
        win_addr = gnt[2] ? req_addr[2*AW +: AW] : gnt[1] ? req_addr[AW +: AW] : req_addr[0 +: AW];
        win_data = gnt[2] ? req_data[2*DW +: DW] : gnt[1] ? req_data[DW +: DW] : req_data[0 +: DW];
        ptr_n = gnt[0] ? 2'd1 : gnt[1] ? 2'd2 : gnt[2] ? 2'd0 : ptr;
        set_v = (iss_vld && iss_addr != '0) ? (2**AW)'(1) << iss_addr : '0;
        clr_v = L_S ? (2**AW)'(1) << Wt_addr : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr     <= 2'd0;
            L_S     <= 1'b0;
            Wt_addr <= '0;
            wt_data <= '0;
            pend    <= '0;
        end else begin
            ptr  <= ptr_n;
            L_S  <= |gnt && win_addr != '0;
            // set after clear so a re-reservation on the commit edge survives
            pend <= ((pend & ~clr_v) | set_v) & ~(2**AW)'(1);
            if (|gnt) begin
                Wt_addr <= win_addr;
                wt_data <= win_data;
            end
        end
    end
`ifdef WB_BYPASS_EN
    always_comb begin
        byp_vld_A  = L_S && Wt_addr == chk_addr_A && chk_addr_A != '0;
        byp_vld_B  = L_S && Wt_addr == chk_addr_B && chk_addr_B != '0;
        byp_data_A = wt_data;
        byp_data_B = wt_data;
        busy_A = rst && pend[chk_addr_A] && !(byp_vld_A && !(iss_vld && iss_addr == chk_addr_A));
        busy_B = rst && pend[chk_addr_B] && !(byp_vld_B && !(iss_vld && iss_addr == chk_addr_B));
    end
`else
    always_comb begin
        busy_A = rst && pend[chk_addr_A];
        busy_B = rst && pend[chk_addr_B];
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  gnt;
    logic        L_S;
    logic [4:0]  Wt_addr;
    logic [31:0] wt_data;
    logic        iss_vld;
    logic [4:0]  iss_addr;
    logic [4:0]  chk_addr_A;
    logic [4:0]  chk_addr_B;
    logic        busy_A;
    logic        busy_B;
`ifdef WB_BYPASS_EN
    logic        byp_vld_A;
    logic        byp_vld_B;
    logic [31:0] byp_data_A;
    logic [31:0] byp_data_B;
`endif
    logic [31:0] pend;
    int total = 0;
    int bad = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .L_S(L_S), .Wt_addr(Wt_addr), .wt_data(wt_data),
        .iss_vld(iss_vld), .iss_addr(iss_addr), .chk_addr_A(chk_addr_A), .chk_addr_B(chk_addr_B),
        .busy_A(busy_A), .busy_B(busy_B),
`ifdef WB_BYPASS_EN
        .byp_vld_A(byp_vld_A), .byp_vld_B(byp_vld_B), .byp_data_A(byp_data_A), .byp_data_B(byp_data_B),
`endif
        .pend(pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        req = 3'b111;
        req_addr = {5'd3, 5'd2, 5'd1};
        req_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        iss_vld = 1'b0;
        iss_addr = 5'd0;
        chk_addr_A = 5'd5;
        chk_addr_B = 5'd6;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ls", 32'(L_S), 32'd0);
        chk("rst_pend", pend, 32'd0);
        chk("rst_busy", 32'(busy_A), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_gnt", 32'(gnt), 32'b001);
        for (int i = 0; i < 6; i++) begin
            chk("rr_gnt", 32'(gnt), 32'(3'b001 << (i % 3)));
            step();
            chk("rr_ls", 32'(L_S), 32'd1);
            chk("rr_addr", 32'(Wt_addr), 32'((i % 3) + 1));
        end
        chk("rr_data", wt_data, 32'h3333_0003);
        req = 3'b000;
        #1;
        chk("idle_gnt", 32'(gnt), 32'd0);
        step();
        chk("idle_ls", 32'(L_S), 32'd0);
        chk("idle_hold_addr", 32'(Wt_addr), 32'd3);
        chk("idle_hold_data", wt_data, 32'h3333_0003);
        req = 3'b010;
        req_addr[9:5] = 5'd7;
        req_data[63:32] = 32'hDEAD_BEEF;
        #1;
        chk("single_gnt", 32'(gnt), 32'b010);
        step();
        req = 3'b000;
        chk("single_ls", 32'(L_S), 32'd1);
        chk("single_addr", 32'(Wt_addr), 32'd7);
        chk("single_data", wt_data, 32'hDEAD_BEEF);
        req = 3'b001;
        req_addr[4:0] = 5'd0;
        req_data[31:0] = 32'h0000_1234;
        #1;
        chk("r0_gnt", 32'(gnt), 32'b001);
        step();
        req = 3'b000;
        chk("r0_ls", 32'(L_S), 32'd0);
        chk("r0_data", wt_data, 32'h0000_1234);
        chk("r0_pend", pend, 32'd0);
        iss_vld = 1'b1;
        iss_addr = 5'd5;
        step();
        iss_vld = 1'b0;
        #1;
        chk("sb_pend_set", pend, 32'h0000_0020);
        chk("sb_busy_A", 32'(busy_A), 32'd1);
        chk("sb_busy_B", 32'(busy_B), 32'd0);
        req = 3'b100;
        req_addr[14:10] = 5'd5;
        req_data[95:64] = 32'hAAAA_5555;
        #1;
        chk("sb_wr_gnt", 32'(gnt), 32'b100);
        step();
        req = 3'b000;
        chk("sb_commit_ls", 32'(L_S), 32'd1);
        chk("sb_commit_addr", 32'(Wt_addr), 32'd5);
        chk("sb_commit_busy", 32'(busy_A), 32'd1);
        step();
        chk("sb_pend_clr", pend, 32'd0);
        chk("sb_busy_clr", 32'(busy_A), 32'd0);
        iss_vld = 1'b1;
        iss_addr = 5'd5;
        step();
        iss_vld = 1'b0;
        chk("sb_reissue", pend, 32'h0000_0020);
        req = 3'b001;
        req_addr[4:0] = 5'd5;
        #1;
        chk("sb_race_gnt", 32'(gnt), 32'b001);
        step();
        req = 3'b000;
        chk("sb_race_ls", 32'(L_S), 32'd1);
        iss_vld = 1'b1;
        iss_addr = 5'd5;
        step();
        iss_vld = 1'b0;
        chk("sb_set_wins", pend, 32'h0000_0020);
        iss_vld = 1'b1;
        iss_addr = 5'd0;
        step();
        iss_vld = 1'b0;
        chk("sb_r0_ignored", pend, 32'h0000_0020);
        req = 3'b010;
        req_addr[9:5] = 5'd9;
        #1;
        chk("mid_gnt", 32'(gnt), 32'b010);
        step();
        chk("mid_ls", 32'(L_S), 32'd1);
        chk("mid_addr", 32'(Wt_addr), 32'd9);
        rst = 1'b0;
        req = 3'b111;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy_A), 32'd0);
        step();
        chk("mid_ls_clr", 32'(L_S), 32'd0);
        chk("mid_pend_clr", pend, 32'd0);
        chk("mid_addr_clr", 32'(Wt_addr), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_ptr0", 32'(gnt), 32'b001);
        req = 3'b000;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file (r0 hardwired to zero; write strobe L_S, address Wt_addr, data wt_data) between three writeback requesters: 0 = ALU, 1 = load unit, 2 = coprocessor/MFC.
- Uses a round-robin arbiter with a req/gnt handshake and a registered write stage.
- Keeps a pending-write scoreboard so the issue stage can stall on read-after-write hazards.

Parameters:
- NREQ, 3, number of writeback requesters (fixed at 3 for this revision).
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low.
- req  in  3  per-requester write request.
- req_addr  in  15  destination address; requester i uses bits [5i+4:5i].
- req_data  in  96  write data; requester i uses bits [32i+31:32i].
- gnt  out  3  one-hot grant, combinational, same cycle as req.
- L_S  out  1  registered write strobe to the register file.
- Wt_addr  out  5  registered write address.
- wt_data  out  32  registered write data.
- iss_vld  in  1  issue stage reserves a destination register.
- iss_addr  in  5  register being reserved.
- chk_addr_A  in  5  first source address to check.
- chk_addr_B  in  5  second source address to check.
- busy_A  out  1  chk_addr_A has a pending write.
- busy_B  out  1  chk_addr_B has a pending write.
- pend  out  32  scoreboard vector; bit 0 is always 0.

Behaviour:
- Reset (rst==0 at a clock edge):
  - L_S, Wt_addr, wt_data, pend all clear to 0.
  - Round-robin pointer resets to 0.
  - gnt and busy outputs are 0 while rst==0, regardless of the other inputs.
- Arbitration, combinational from req and pointer ptr:
  - Search order is ptr, ptr+1, ptr+2, modulo 3.
  - The first requester found with req=1 gets gnt. At most one gnt bit is ever set.
- Handshake:
  - A request completes in the cycle req[i] && gnt[i] holds.
  - The requester holds req, addr and data stable until granted, then may drop or change them the next cycle.
- Pointer update:
  - On a grant to requester i, ptr becomes (i+1) mod 3 at the next edge.
  - With no grant, ptr is unchanged.
- Write stage:
  - On a grant, the next edge loads Wt_addr and wt_data from the winning requester.
  - L_S is set to 1 if that address is nonzero, otherwise 0.
  - With no grant, L_S=0 and Wt_addr/wt_data hold their previous values.
  - Latency: request granted in cycle N, register file written at the edge ending cycle N+1.
- Address-0 grants: granted and consumed normally, but L_S stays 0 and the scoreboard is not touched.
- Scoreboard:
  - pend[a] is set at an edge where iss_vld=1 and iss_addr=a, for a≠0.
  - pend[a] is cleared at the edge where the write stage commits to a, i.e. L_S=1 and Wt_addr=a are being presented.
  - If set and clear hit the same register at the same edge, set wins (a newer producer is in flight).
  - iss_vld with iss_addr=0 is ignored.
  - busy_A = pend[chk_addr_A]; busy_B = pend[chk_addr_B]; both combinational.
  - A register committing in the current cycle still reads busy (no forwarding unless the optional feature is compiled in).
- Simultaneous requests to the same address from two requesters: served in round-robin order; the later grant's data is what remains in the register file.
- Reset mid-operation: any ungranted request is dropped; a pending write-stage entry is discarded (L_S forced to 0); the scoreboard is cleared.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs byp_vld_A/byp_vld_B (1 bit each) and byp_data_A/byp_data_B (32 bits each).
  - byp_vld_X=1 when L_S=1 and Wt_addr==chk_addr_X≠0; byp_data_X=wt_data.
  - busy_X is masked to 0 when byp_vld_X=1, unless iss_vld re-reserves the same register that cycle.
- Not defined: none of these ports exist; busy_X = pend[chk_addr_X] exactly as above.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req=3'b111 -> gnt=0, L_S=0, pend=0. Release rst -> gnt=3'b001 in the first active cycle.
- Single requester: req=3'b010, addr1=7, data1=32'hDEADBEEF in cycle N -> gnt=3'b010 in cycle N; in cycle N+1, L_S=1, Wt_addr=7, wt_data=32'hDEADBEEF.
- Round-robin fairness: req=3'b111 held for 6 cycles -> grant sequence 001, 010, 100, 001, 010, 100.
- r0 write: requester 0 with addr=0, data=32'h1234 -> granted; next cycle L_S=0; pend unchanged.
- Scoreboard:
  - iss_vld with iss_addr=5 -> pend[5]=1, busy_A=1 with chk_addr_A=5.
  - Grant a write to r5 -> pend[5] clears at the commit edge.
  - Issue to r5 on that same edge -> pend[5] stays 1.
- Reset mid-write: grant addr=9 in cycle N, assert rst=0 in cycle N+1 -> L_S=0 after the edge, pend=0, ptr=0.
